time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Owns the digital clock's hours/minutes/seconds registers and lets the user set them from single-cycle click pulses. It sits downstream of the button click-detection blocks and the 1 Hz timebase, and upstream of the 7-segment display drivers. In run mode it counts time on each 1 Hz tick. In edit mode it selects a field, increments or decrements it, and flags that field for blinking.

## Interface
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; ≥2.
- TIMEOUT_S, 10: 1 Hz ticks with no click before edit mode auto-exits to run; ≥1.
- clock  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- tick_1hz  in  1  one-cycle pulse, once per second.
- mode_click  in  1  one-cycle pulse: advance edit state.
- inc_click  in  1  one-cycle pulse: increment selected field.
- dec_click  in  1  one-cycle pulse: decrement selected field.
- hours  out  5  0..23.
- minutes  out  6  0..59.
- seconds  out  6  0..59.
- edit_field  out  2  0=none, 1=hours, 2=minutes, 3=seconds.
- blank  out  1  1 = display should blank the selected field this phase.

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC.
- mode_click transitions: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- edit_field encodes the state directly: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
- RUN behaviour:
  - tick_1hz increments seconds.
  - seconds 59→0 carries into minutes; minutes 59→0 carries into hours; hours 23→0.
  - 23:59:59 + tick → 00:00:00.
  - inc_click and dec_click are ignored.
- Edit state behaviour:
  - tick_1hz never advances time; it only feeds the timeout counter.
  - inc_click adds 1 to the selected field, dec_click subtracts 1.
  - Wrap is per field only (hours 23↔0, min/sec 59↔0), with no carry or borrow into other fields.
- Simultaneous events:
  - mode_click with inc or dec: mode wins and inc/dec is dropped.
  - inc_click with dec_click: both are dropped, but they still count as a click for the timeout.
- Timeout:
  - The counter clears on entering any edit state and on any click.
  - It increments on each tick_1hz while in an edit state.
  - When the count reaches TIMEOUT_S, the next cycle state is RUN.
  - If mode_click arrives in the same cycle as the reaching tick, mode_click takes priority.
- Blink:
  - The counter runs only in edit states and toggles blink_phase every BLINK_DIV cycles.
  - Counter and phase clear to 0 on entering any edit state and on any accepted inc/dec, so a new value shows immediately.
  - blank = (state≠RUN) && blink_phase.
- Field values outside their legal range are unreachable. If reached anyway, the next increment forces the field to 0.

## Timing
- Reset (rst=0, asynchronous):
  - state=RUN, hours=0, minutes=0, seconds=0, edit_field=0, blank=0.
  - Timeout and blink counters cleared.
- Reset release is synchronous to clock.
- Reset mid-edit discards the edit and returns to 00:00:00 RUN.
- All outputs are registered. A pulse sampled at edge n shows its effect on the outputs after edge n (1-cycle latency).
- Inputs are one cycle wide. A pulse held high for k cycles acts as k events; upstream guarantees single cycles.
- blank rises BLINK_DIV cycles after edit entry, then toggles every BLINK_DIV cycles.
- Timeout exit: edit_field=0 one cycle after the TIMEOUT_S-th tick.

## Structure
- Shared package clock_pkg:
  - edit_state_t enum (RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3).
  - Constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - Field widths 5/6/6.
- Sub-module wrap_counter:
  - Parameters: MAX and W.
  - Inputs: clock, rst, up, down.
  - Outputs: value, carry (pulses when MAX→0 on up).
  - Up and down together are a no-op.
  - Instantiated three times. The top level gates up/down per state and chains carry only in RUN.
- Top level: state FSM, timeout counter, blink divider.

## Test plan
- Reset then 86400 ticks in RUN (start 00:00:00):
  - 23:59:59 + tick → 00:00:00.
  - After 61 ticks from reset: 00:01:01.
- From 10:20:30 RUN:
  - mode → edit_field=1.
  - 14 inc → hours=0 (wrap 23→0).
  - minutes and seconds unchanged.
- SET_MIN at minutes=0:
  - dec → 59, hours unchanged.
  - Then a tick_1hz → seconds unchanged.
- SET_SEC with mode_click and inc_click in the same cycle:
  - state=RUN, seconds unchanged.
- SET_HOUR with TIMEOUT_S=3 and no clicks:
  - edit_field=0 one cycle after the 3rd tick.
  - Repeat with an inc between ticks 2 and 3 → still editing after tick 3.
- BLINK_DIV=4, enter SET_HOUR:
  - blank=0 for cycles 1–4, 1 for cycles 5–8.
  - An inc at cycle 6 → blank=0 the next cycle and stays 0 for 4 cycles.
- Assert rst=0 mid-edit, asynchronously between edges:
  - All outputs 0 immediately.
  - RUN on release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and field limits for the digital clock time registers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } edit_state_t;

   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int SEC_W    = 6;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;
   localparam int SEC_MAX  = 59;

   // mode_click walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
   function automatic edit_state_t next_edit_state(input edit_state_t s);
      edit_state_t n;
      case (s)
         RUN:      n = SET_HOUR;
         SET_HOUR: n = SET_MIN;
         SET_MIN:  n = SET_SEC;
         default:  n = RUN;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up/down counter with a carry pulse on the MAX->0 up-step.
// Latency: value updates one cycle after up/down; carry is combinational from the current value.
// Backpressure: none; up and down together are a no-op.
module wrap_counter #(
   parameter int MAX = 59,
   parameter int W   = 6
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         up,
   input  logic         down,
   output logic [W-1:0] value,
   output logic         carry
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   // Next value: an out-of-range value snaps to 0 on the next increment
   always_comb begin
      value_d = value_q;
      if (up && !down) begin
         value_d = (value_q >= MAX_V) ? '0 : value_q + 1'b1;
      end else if (down && !up) begin
         value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
      end
   end

   // Value register
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) value_q <= '0;
      else      value_q <= value_d;
   end

   assign value = value_q;
   assign carry = up && !down && (value_q == MAX_V);

endmodule

// File: rtl/time_set_ctrl.sv
// Clock hours/minutes/seconds registers: 1 Hz counting in RUN, per-field set with blink in edit states.
// Latency: one cycle from a sampled click/tick to the registered outputs.
// Backpressure: none; every single-cycle pulse is consumed in the cycle it arrives.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int BLINK_DIV = 25_000_000,
   parameter int TIMEOUT_S = 10
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              tick_1hz,
   input  logic              mode_click,
   input  logic              inc_click,
   input  logic              dec_click,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic [1:0]        edit_field,
   output logic              blank
);

   localparam int TO_W = $clog2(TIMEOUT_S + 1);
   localparam int BD_W = $clog2(BLINK_DIV);

   edit_state_t     state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [BD_W-1:0] blink_cnt_q, blink_cnt_d;
   logic            blink_phase_q, blink_phase_d;
   logic            blank_q, blank_d;

   logic in_edit, any_click, step_ok, inc_ok, dec_ok, timeout_hit;
   logic sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn;
   logic sec_carry, min_carry, hr_carry;

   assign in_edit   = (state_q != RUN);
   assign any_click = mode_click | inc_click | dec_click;
   // inc/dec only count in edit, lose to mode, and cancel each other out
   assign step_ok   = in_edit && !mode_click && (inc_click ^ dec_click);
   assign inc_ok    = step_ok && inc_click;
   assign dec_ok    = step_ok && dec_click;
   // Tick that brings the idle count to TIMEOUT_S; any click in the same cycle restarts the count
   assign timeout_hit = in_edit && tick_1hz && !any_click &&
                        (to_cnt_q >= TO_W'(TIMEOUT_S - 1));

   // Edit-state FSM: mode_click has priority over the timeout exit
   always_comb begin
      state_d = state_q;
      if (mode_click)       state_d = next_edit_state(state_q);
      else if (timeout_hit) state_d = RUN;
   end

   // Idle timeout counter: counts ticks only while editing with no clicks
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (!in_edit || any_click || timeout_hit) to_cnt_d = '0;
      else if (tick_1hz)                        to_cnt_d = to_cnt_q + 1'b1;
   end

   // Blink divider: restarts on state change and accepted edits so the new value shows solid
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (state_d == RUN || mode_click || step_ok) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BD_W'(BLINK_DIV - 1)) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d   = blink_cnt_q + 1'b1;
      end
      blank_d = (state_d != RUN) && blink_phase_d;
   end

   // Control registers
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q       <= RUN;
         to_cnt_q      <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         blank_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         to_cnt_q      <= to_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         blank_q       <= blank_d;
      end
   end

   // Field steering: carries chain only in RUN, edits touch just the selected field
   always_comb begin
      sec_up = in_edit ? (state_q == SET_SEC  && inc_ok) : tick_1hz;
      min_up = in_edit ? (state_q == SET_MIN  && inc_ok) : sec_carry;
      hr_up  = in_edit ? (state_q == SET_HOUR && inc_ok) : min_carry;
      sec_dn = (state_q == SET_SEC)  && dec_ok;
      min_dn = (state_q == SET_MIN)  && dec_ok;
      hr_dn  = (state_q == SET_HOUR) && dec_ok;
   end

   wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
      .clock(clock), .rst(rst), .up(sec_up), .down(sec_dn),
      .value(seconds), .carry(sec_carry)
   );

   wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
      .clock(clock), .rst(rst), .up(min_up), .down(min_dn),
      .value(minutes), .carry(min_carry)
   );

   wrap_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hr (
      .clock(clock), .rst(rst), .up(hr_up), .down(hr_dn),
      .value(hours), .carry(hr_carry)
   );

   assign edit_field = state_q;
   assign blank      = blank_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: reference model feeds a scoreboard, plus directed checks.
// Latency: expects outputs one cycle after each driven pulse.
// Backpressure: n/a.
module tb_time_set_ctrl;
   import clock_pkg::*;

   localparam int BD = 4;
   localparam int TO = 3;

   logic       clock = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       mode_click = 1'b0;
   logic       inc_click = 1'b0;
   logic       dec_click = 1'b0;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [1:0] edit_field;
   logic       blank;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [1:0] ef;
      logic       bl;
   } exp_t;

   exp_t sb[$];

   int m_state, m_h, m_m, m_s, m_to, m_bc, m_ph;

   always #5 clock = ~clock;

   time_set_ctrl #(.BLINK_DIV(BD), .TIMEOUT_S(TO)) dut (
      .clock(clock), .rst(rst), .tick_1hz(tick_1hz),
      .mode_click(mode_click), .inc_click(inc_click), .dec_click(dec_click),
      .hours(hours), .minutes(minutes), .seconds(seconds),
      .edit_field(edit_field), .blank(blank)
   );

   task automatic model_reset();
      m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_to = 0; m_bc = 0; m_ph = 0;
      sb.delete();
   endtask

   // Behavioural reference: computes the expected post-edge outputs and queues them
   task automatic model_step(input logic md, input logic inc, input logic dec, input logic tk);
      int   ns;
      int   d;
      exp_t e;
      bit   edit;
      bit   click;
      bit   acc;
      edit  = (m_state != 0);
      click = md | inc | dec;
      acc   = edit && !md && (inc != dec);
      if (!edit) begin
         if (tk) begin
            m_s = m_s + 1;
            if (m_s == 60) begin
               m_s = 0;
               m_m = m_m + 1;
               if (m_m == 60) begin
                  m_m = 0;
                  m_h = (m_h + 1) % 24;
               end
            end
         end
      end else if (acc) begin
         d = inc ? 1 : -1;
         case (m_state)
            1:       m_h = (m_h + d + 24) % 24;
            2:       m_m = (m_m + d + 60) % 60;
            default: m_s = (m_s + d + 60) % 60;
         endcase
      end
      if (md)                                     ns = (m_state + 1) % 4;
      else if (edit && tk && !click && m_to == TO - 1) ns = 0;
      else                                        ns = m_state;
      if (!edit || click) m_to = 0;
      else if (tk)        m_to = m_to + 1;
      if (ns == 0 || md || acc) begin
         m_bc = 0; m_ph = 0;
      end else if (m_bc == BD - 1) begin
         m_bc = 0; m_ph = 1 - m_ph;
      end else begin
         m_bc = m_bc + 1;
      end
      m_state = ns;
      e.h  = 5'(m_h);
      e.m  = 6'(m_m);
      e.s  = 6'(m_s);
      e.ef = 2'(m_state);
      e.bl = (m_state != 0) && (m_ph != 0);
      sb.push_back(e);
   endtask

   // One clock of stimulus; the queued expectation is popped and compared after the edge
   task automatic step(input logic md, input logic inc, input logic dec, input logic tk);
      exp_t e;
      @(negedge clock);
      mode_click = md; inc_click = inc; dec_click = dec; tick_1hz = tk;
      model_step(md, inc, dec, tk);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({hours, minutes, seconds, edit_field, blank} !== e) begin
         miscompares++;
         $display("FAIL scoreboard t=%0t got %0d:%0d:%0d ef=%0d bl=%0d expected %0d:%0d:%0d ef=%0d bl=%0d",
                  $time, hours, minutes, seconds, edit_field, blank, e.h, e.m, e.s, e.ef, e.bl);
      end
      #1;
      mode_click = 1'b0; inc_click = 1'b0; dec_click = 1'b0; tick_1hz = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({hours, minutes, seconds, edit_field, blank} !== 20'd0) begin
         miscompares++;
         $display("FAIL reset_state got %0d:%0d:%0d ef=%0d bl=%0d expected all 0",
                  hours, minutes, seconds, edit_field, blank);
      end
      do_reset();
      step(0, 0, 0, 0);
   endtask

   task automatic test_run_count();
      do_reset();
      repeat (61) step(0, 0, 0, 1);
      vectors++;
      if ({hours, minutes, seconds} !== {5'd0, 6'd1, 6'd1}) begin
         miscompares++;
         $display("FAIL run_61_ticks got %0d:%0d:%0d expected 0:1:1", hours, minutes, seconds);
      end
      repeat (3600) step(0, 0, 0, 1);
      vectors++;
      if ({hours, minutes, seconds} !== {5'd1, 6'd1, 6'd1}) begin
         miscompares++;
         $display("FAIL run_3661_ticks got %0d:%0d:%0d expected 1:1:1", hours, minutes, seconds);
      end
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      vectors++;
      if ({hours, minutes, seconds} !== {5'd1, 6'd1, 6'd2}) begin
         miscompares++;
         $display("FAIL run_ignores_incdec got %0d:%0d:%0d expected 1:1:2", hours, minutes, seconds);
      end
   endtask

   task automatic test_midnight_wrap();
      do_reset();
      step(1, 0, 0, 0); step(0, 0, 1, 0);
      step(1, 0, 0, 0); step(0, 0, 1, 0);
      step(1, 0, 0, 0); step(0, 0, 1, 0);
      step(1, 0, 0, 0);
      vectors++;
      if ({hours, minutes, seconds, edit_field} !== {5'd23, 6'd59, 6'd59, 2'd0}) begin
         miscompares++;
         $display("FAIL set_235959 got %0d:%0d:%0d ef=%0d expected 23:59:59 ef=0",
                  hours, minutes, seconds, edit_field);
      end
      step(0, 0, 0, 1);
      vectors++;
      if ({hours, minutes, seconds} !== 17'd0) begin
         miscompares++;
         $display("FAIL midnight_wrap got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds);
      end
   endtask

   task automatic test_hour_edit();
      do_reset();
      step(1, 0, 0, 0); repeat (10) step(0, 1, 0, 0);
      step(1, 0, 0, 0); repeat (20) step(0, 1, 0, 0);
      step(1, 0, 0, 0); repeat (30) step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      vectors++;
      if (edit_field !== 2'd1) begin
         miscompares++;
         $display("FAIL enter_set_hour got ef=%0d expected 1", edit_field);
      end
      repeat (14) step(0, 1, 0, 0);
      vectors++;
      if ({hours, minutes, seconds} !== {5'd0, 6'd20, 6'd30}) begin
         miscompares++;
         $display("FAIL hour_wrap_no_carry got %0d:%0d:%0d expected 0:20:30", hours, minutes, seconds);
      end
   endtask

   task automatic test_min_dec();
      do_reset();
      step(1, 0, 0, 0); repeat (5) step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      vectors++;
      if ({hours, minutes, edit_field} !== {5'd5, 6'd59, 2'd2}) begin
         miscompares++;
         $display("FAIL min_dec_wrap got h=%0d m=%0d ef=%0d expected h=5 m=59 ef=2",
                  hours, minutes, edit_field);
      end
      step(0, 0, 0, 1);
      vectors++;
      if ({seconds, edit_field} !== {6'd0, 2'd2}) begin
         miscompares++;
         $display("FAIL edit_tick_frozen got s=%0d ef=%0d expected s=0 ef=2", seconds, edit_field);
      end
      step(0, 1, 1, 0);
      vectors++;
      if (minutes !== 6'd59) begin
         miscompares++;
         $display("FAIL inc_dec_cancel got m=%0d expected 59", minutes);
      end
   endtask

   task automatic test_mode_priority();
      step(1, 0, 0, 0);
      repeat (7) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      vectors++;
      if ({edit_field, seconds} !== {2'd0, 6'd7}) begin
         miscompares++;
         $display("FAIL mode_beats_inc got ef=%0d s=%0d expected ef=0 s=7", edit_field, seconds);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      step(1, 0, 0, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 0);
      vectors++;
      if (edit_field !== 2'd1) begin
         miscompares++;
         $display("FAIL before_timeout got ef=%0d expected 1", edit_field);
      end
      step(0, 0, 0, 1);
      vectors++;
      if (edit_field !== 2'd0) begin
         miscompares++;
         $display("FAIL timeout_exit got ef=%0d expected 0", edit_field);
      end
      step(1, 0, 0, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      vectors++;
      if ({edit_field, hours} !== {2'd1, 5'd1}) begin
         miscompares++;
         $display("FAIL click_restarts_timeout got ef=%0d h=%0d expected ef=1 h=1", edit_field, hours);
      end
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      vectors++;
      if (edit_field !== 2'd0) begin
         miscompares++;
         $display("FAIL timeout_after_click got ef=%0d expected 0", edit_field);
      end
      step(1, 0, 0, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      vectors++;
      if (edit_field !== 2'd2) begin
         miscompares++;
         $display("FAIL mode_beats_timeout got ef=%0d expected 2", edit_field);
      end
   endtask

   task automatic test_blink();
      do_reset();
      step(1, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) step(0, 0, 0, 0);
         vectors++;
         if (blank !== (k >= 5)) begin
            miscompares++;
            $display("FAIL blink_cycle_%0d got blank=%0d expected %0d", k, blank, (k >= 5));
         end
      end
      do_reset();
      step(1, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0);
      vectors++;
      if (blank !== 1'b1) begin
         miscompares++;
         $display("FAIL blink_cycle6 got blank=%0d expected 1", blank);
      end
      for (int k = 7; k <= 11; k++) begin
         if (k == 7) step(0, 1, 0, 0);
         else        step(0, 0, 0, 0);
         vectors++;
         if (blank !== (k == 11)) begin
            miscompares++;
            $display("FAIL blink_after_inc_cycle_%0d got blank=%0d expected %0d", k, blank, (k == 11));
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1, 0, 0, 0); repeat (3) step(0, 1, 0, 0);
      step(1, 0, 0, 0); repeat (2) step(0, 1, 0, 0);
      @(negedge clock);
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if ({hours, minutes, seconds, edit_field, blank} !== 20'd0) begin
         miscompares++;
         $display("FAIL async_reset got %0d:%0d:%0d ef=%0d bl=%0d expected all 0",
                  hours, minutes, seconds, edit_field, blank);
      end
      model_reset();
      @(posedge clock);
      @(negedge clock);
      rst = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      vectors++;
      if ({edit_field, seconds} !== {2'd0, 6'd1}) begin
         miscompares++;
         $display("FAIL run_after_reset got ef=%0d s=%0d expected ef=0 s=1", edit_field, seconds);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_count();
      test_midnight_wrap();
      test_hour_edit();
      test_min_dec();
      test_mode_priority();
      test_timeout();
      test_blink();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
